csync_sequencer: RTL and testbench
==================================

Name: csync_sequencer

Overview:
- Builds the composite sync waveform for analog video output.
- On each line start it chooses one of four line types: normal hsync, pre-equalization, vertical serration, or post-equalization.
- From that type and raster_x it produces a registered active-low csync plus a vsync_n flag.
- It sits beside the raster counters and feeds the composite/luma output stage. Each line-type window is chip-dependent.

Parameters:
- NTSC_EQ_START, 9'd13: raster_y that begins pre-equalization for 6567R8/6567R56A.
- PAL_EQ_START, 9'd300: raster_y that begins pre-equalization for 6569R1/6569R3.
- LINES_PER_PHASE, 2'd3: number of lines in each of PRE_EQ, VSYNC and POST_EQ.
- HS_START, 10'd10: raster_x where every sync window starts.

Ports:
- clk_dot4x  in  1  4x dot clock; the single clock.
- rst_n  in  1  synchronous, active-low reset.
- chip  in  2  `CHIP6567R8 / `CHIP6567R56A / `CHIP6569R1 / `CHIP6569R3.
- raster_x  in  10  current dot x; holds for 4 clk_dot4x cycles per dot.
- raster_y  in  9  current raster line.
- sync_en  in  1  0 forces csync=1 and vsync_n=1; state still advances.
- csync  out  1  composite sync, active low, registered.
- vsync_n  out  1  low during the VSYNC phase lines.
- phase  out  2  0=NORMAL, 1=PRE_EQ, 2=VSYNC, 3=POST_EQ.
- field_sync  out  1  one-cycle pulse on entry to PRE_EQ.

Behaviour:
- Interface: one clock, clk_dot4x; reset rst_n is synchronous and active-low.
- Reset values while rst_n=0 at a clk_dot4x edge: phase=NORMAL, line count=0, csync=1, vsync_n=1, field_sync=0, prev_x=0.
- Reset mid-sequence aborts immediately; waveform resumes as NORMAL.
- Line-start event (ls) is true when raster_x==HS_START and prev_x!=HS_START.
  - prev_x registers raster_x every cycle.
  - ls is therefore exactly one clk_dot4x cycle per line.
- State machine, updated on ls only:
  - NORMAL: if raster_y==EQ_START(chip), go to PRE_EQ, cnt=0, field_sync=1 for that cycle.
  - PRE_EQ, VSYNC, POST_EQ: if cnt==LINES_PER_PHASE-1, go to the next phase with cnt=0; otherwise cnt+1.
  - POST_EQ exits to NORMAL.
  - A raster_y match while not in NORMAL is ignored; there is no re-trigger.
- Line type: the phase value after the ls update governs the whole line, including the ls cycle itself.
- Low windows (half-open intervals, x = raster_x):
  - Equalization pulse width E: R8=21, R56A=20, PAL=20.
  - Half-line offset H: R8=260, R56A=256, PAL=252.
  - Serration end S1/S2: R8=234/494, R56A=230/486, PAL=227/479.
  - Normal hsync width W: R8=38, R56A=38, PAL=37.
- csync low conditions per phase:
  - NORMAL: [10, 10+W).
  - PRE_EQ and POST_EQ: [10, 10+E) or [10+H, 10+H+E).
  - VSYNC: [10, S1) or [10+H, S2).
- csync is a registered version of the window decode; 1 clk_dot4x latency from raster_x.
- vsync_n is a registered version of (phase!=VSYNC); same 1-cycle latency.
- sync_en=0 overrides both outputs to 1 at the register input.
- chip changes take effect on the next cycle for window decode and on the next ls for the start-line compare. An in-progress sequence continues.
- Unknown chip encoding is impossible (2-bit, all four codes defined).
- Arithmetic: all x compares are 10-bit unsigned; constants fit, so no wrap.

Test Plan:
- Reset mid-VSYNC (line 2) → next cycle phase=0, csync=1, vsync_n=1; the following line shows a normal 38-dot hsync (R8).
- R8, sweep raster_y 10..25 → PRE_EQ on lines 13-15, VSYNC on 16-18, POST_EQ on 19-21, NORMAL from 22; field_sync pulses once, at line 13's ls.
- R8 VSYNC line → csync low for x in [10,234) and [270,494), high at x=234..269 and 494..519, each edge lagging raster_x by exactly one clk_dot4x cycle.
- PAL PRE_EQ line → csync low only for x in [10,30) and [262,282); NORMAL line low only for [10,47).
- raster_x held at 10 for 4 cycles → a single ls; cnt advances by 1, not 4.
- sync_en=0 during VSYNC → csync=1 and vsync_n=1 throughout, but phase still reaches NORMAL at line 22; re-enabling mid-field restores the waveform on the next cycle.

Source files
------------

// File: rtl/csync_sequencer.sv
// Composite sync sequencer: picks a line type at each line start, then decodes csync/vsync_n from raster_x.
// Outputs are registered, one clk_dot4x behind raster_x; no backpressure (free-running raster timing).
`ifndef CHIP6567R8
`define CHIP6567R8   2'd0
`endif
`ifndef CHIP6569R3
`define CHIP6569R3   2'd1
`endif
`ifndef CHIP6567R56A
`define CHIP6567R56A 2'd2
`endif
`ifndef CHIP6569R1
`define CHIP6569R1   2'd3
`endif

module csync_sequencer #(
    parameter logic [8:0] NTSC_EQ_START   = 9'd13,
    parameter logic [8:0] PAL_EQ_START    = 9'd300,
    parameter logic [1:0] LINES_PER_PHASE = 2'd3,
    parameter logic [9:0] HS_START        = 10'd10
) (
    input  logic       clk_dot4x,
    input  logic       rst_n,
    input  logic [1:0] chip,
    input  logic [9:0] raster_x,
    input  logic [8:0] raster_y,
    input  logic       sync_en,
    output logic       csync,
    output logic       vsync_n,
    output logic [1:0] phase,
    output logic       field_sync
);

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        PRE_EQ  = 2'd1,
        VSYNC   = 2'd2,
        POST_EQ = 2'd3
    } phase_t;

    phase_t     phase_q, phase_nxt;
    logic [1:0] cnt_q, cnt_nxt;
    logic [9:0] prev_x;
    logic       ls, fs_nxt;
    logic       is_pal;
    logic [8:0] eq_start;
    logic [9:0] eq_w, half, s1, s2, hs_w;
    logic       low, csync_d, vsync_d;

    // raster_x dwells on each dot for several cycles; only the first cycle at HS_START counts
    assign ls       = (raster_x == HS_START) && (prev_x != HS_START);
    assign is_pal   = (chip == `CHIP6569R1) || (chip == `CHIP6569R3);
    assign eq_start = is_pal ? PAL_EQ_START : NTSC_EQ_START;
    assign phase    = phase_q;

    always_ff @(posedge clk_dot4x) begin
        if (!rst_n) begin
            phase_q    <= NORMAL;
            cnt_q      <= 2'd0;
            prev_x     <= 10'd0;
            field_sync <= 1'b0;
            csync      <= 1'b1;
            vsync_n    <= 1'b1;
        end else begin
            phase_q    <= phase_nxt;
            cnt_q      <= cnt_nxt;
            prev_x     <= raster_x;
            field_sync <= fs_nxt;
            csync      <= csync_d;
            vsync_n    <= vsync_d;
        end
    end

    always_comb begin
        phase_nxt = phase_q;
        cnt_nxt   = cnt_q;
        fs_nxt    = 1'b0;
        if (ls) begin
            if (phase_q == NORMAL) begin
                if (raster_y == eq_start) begin
                    phase_nxt = PRE_EQ;
                    cnt_nxt   = 2'd0;
                    fs_nxt    = 1'b1;
                end
            end else if (cnt_q == LINES_PER_PHASE - 2'd1) begin
                // POST_EQ + 1 wraps to NORMAL
                phase_nxt = phase_t'(phase_q + 2'd1);
                cnt_nxt   = 2'd0;
            end else begin
                cnt_nxt = cnt_q + 2'd1;
            end
        end
    end

    always_comb begin
        case (chip)
            `CHIP6567R8: begin
                eq_w = 10'd21; half = 10'd260; s1 = 10'd234; s2 = 10'd494; hs_w = 10'd38;
            end
            `CHIP6567R56A: begin
                eq_w = 10'd20; half = 10'd256; s1 = 10'd230; s2 = 10'd486; hs_w = 10'd38;
            end
            default: begin
                eq_w = 10'd20; half = 10'd252; s1 = 10'd227; s2 = 10'd479; hs_w = 10'd37;
            end
        endcase
    end

    // Decode from the post-update phase so the ls cycle already belongs to the new line type
    always_comb begin
        low = 1'b0;
        case (phase_nxt)
            NORMAL:
                low = (raster_x >= HS_START) && (raster_x < HS_START + hs_w);
            VSYNC:
                low = ((raster_x >= HS_START) && (raster_x < s1)) ||
                      ((raster_x >= HS_START + half) && (raster_x < s2));
            default:
                low = ((raster_x >= HS_START) && (raster_x < HS_START + eq_w)) ||
                      ((raster_x >= HS_START + half) && (raster_x < HS_START + half + eq_w));
        endcase
        csync_d = !(sync_en && low);
        vsync_d = !(sync_en && (phase_nxt == VSYNC));
    end

endmodule

// File: tb/tb_csync_sequencer.sv
// Directed bench for csync_sequencer: field sweep table, window point table, reset/hold/enable sequences.
module tb_csync_sequencer;

    localparam logic [1:0] C_R8   = 2'd0;
    localparam logic [1:0] C_PAL3 = 2'd1;

    logic       clk_dot4x = 1'b0;
    logic       rst_n;
    logic [1:0] chip;
    logic [9:0] raster_x;
    logic [8:0] raster_y;
    logic       sync_en;
    logic       csync, vsync_n, field_sync;
    logic [1:0] phase;

    csync_sequencer dut (
        .clk_dot4x (clk_dot4x),
        .rst_n     (rst_n),
        .chip      (chip),
        .raster_x  (raster_x),
        .raster_y  (raster_y),
        .sync_en   (sync_en),
        .csync     (csync),
        .vsync_n   (vsync_n),
        .phase     (phase),
        .field_sync(field_sync)
    );

    always #5 clk_dot4x = ~clk_dot4x;

    typedef struct {
        int y;
        int ph;
        int vs;
        int lows;
    } sweep_t;

    typedef struct {
        int id;
        int x;
        int exp;
    } point_t;

    sweep_t sweep_tab[16];
    point_t pt_tab[];

    int   total = 0;
    int   bad   = 0;
    logic cs [0:519];
    int   lows, vlow, fs_cnt, acc_lows, acc_vlow;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Sweep raster_x 0..last on line y, each dot held rep cycles; cs[x] is csync as registered from x
    task automatic run_line(input int y, input int last, input int rep, input int en_x);
        lows = 0;
        vlow = 0;
        for (int x = 0; x <= last + 1; x++) begin
            for (int r = 0; r < ((x > last) ? 1 : rep); r++) begin
                @(negedge clk_dot4x);
                fs_cnt += int'(field_sync);
                if (r == 0 && x > 0) begin
                    cs[x-1] = csync;
                    if (!csync) lows++;
                    if (!vsync_n) vlow++;
                end
                if (x <= last) begin
                    raster_x = 10'(x);
                    raster_y = 9'(y);
                    if (x == en_x) sync_en = 1'b1;
                end
            end
        end
    endtask

    task automatic check_pts(input int id, input string tag);
        foreach (pt_tab[i]) begin
            if (pt_tab[i].id == id)
                check($sformatf("%s_x%0d", tag, pt_tab[i].x), int'(cs[pt_tab[i].x]), pt_tab[i].exp);
        end
    endtask

    initial begin
        sweep_tab = '{
            '{10, 0, 1, 38},  '{11, 0, 1, 38},  '{12, 0, 1, 38},
            '{13, 1, 1, 42},  '{14, 1, 1, 42},  '{15, 1, 1, 42},
            '{16, 2, 0, 448}, '{17, 2, 0, 448}, '{18, 2, 0, 448},
            '{19, 3, 1, 42},  '{20, 3, 1, 42},  '{21, 3, 1, 42},
            '{22, 0, 1, 38},  '{23, 0, 1, 38},  '{24, 0, 1, 38},  '{25, 0, 1, 38}
        };
        pt_tab = '{
            '{0, 9, 1}, '{0, 10, 0}, '{0, 233, 0}, '{0, 234, 1}, '{0, 269, 1},
            '{0, 270, 0}, '{0, 493, 0}, '{0, 494, 1}, '{0, 519, 1},
            '{1, 9, 1}, '{1, 10, 0}, '{1, 47, 0}, '{1, 48, 1},
            '{2, 9, 1}, '{2, 10, 0}, '{2, 29, 0}, '{2, 30, 1},
            '{2, 261, 1}, '{2, 262, 0}, '{2, 281, 0}, '{2, 282, 1},
            '{3, 10, 0}, '{3, 46, 0}, '{3, 47, 1},
            '{4, 10, 0}, '{4, 47, 0}, '{4, 48, 1},
            '{5, 99, 1}, '{5, 100, 0}, '{5, 233, 0}, '{5, 234, 1}, '{5, 270, 0}
        };

        rst_n = 1'b0; chip = C_R8; raster_x = 10'd0; raster_y = 9'd0; sync_en = 1'b1;
        fs_cnt = 0;
        repeat (3) @(negedge clk_dot4x);
        check("rst_phase", int'(phase), 0);
        check("rst_csync", int'(csync), 1);
        check("rst_vsync_n", int'(vsync_n), 1);
        check("rst_field_sync", int'(field_sync), 0);
        rst_n = 1'b1;

        // R8 field sweep
        foreach (sweep_tab[i]) begin
            run_line(sweep_tab[i].y, 519, 1, -1);
            check($sformatf("sweep_y%0d_phase", sweep_tab[i].y), int'(phase), sweep_tab[i].ph);
            check($sformatf("sweep_y%0d_vsync_n", sweep_tab[i].y), int'(vsync_n), sweep_tab[i].vs);
            check($sformatf("sweep_y%0d_lows", sweep_tab[i].y), lows, sweep_tab[i].lows);
            if (sweep_tab[i].y == 16) check_pts(0, "r8_vsync");
            if (sweep_tab[i].y == 22) check_pts(1, "r8_normal");
        end
        check("sweep_field_sync_pulses", fs_cnt, 1);

        // csync must not follow raster_x combinationally
        for (int x = 0; x < 10; x++) begin
            @(negedge clk_dot4x);
            raster_x = 10'(x); raster_y = 9'd26;
        end
        @(negedge clk_dot4x);
        raster_x = 10'd10;
        #1 check("lag_before_edge", int'(csync), 1);
        @(negedge clk_dot4x);
        check("lag_after_edge", int'(csync), 0);

        // raster_x dwelling on HS_START must count as one line
        fs_cnt = 0;
        run_line(13, 40, 4, -1);
        check("hold_y13_phase", int'(phase), 1);
        run_line(14, 40, 4, -1);
        check("hold_y14_phase", int'(phase), 1);
        run_line(15, 40, 1, -1);
        check("hold_y15_phase", int'(phase), 1);
        run_line(16, 40, 1, -1);
        check("hold_y16_phase", int'(phase), 2);
        check("hold_field_sync_pulses", fs_cnt, 1);

        // reset in the middle of VSYNC line 2
        run_line(17, 100, 1, -1);
        check("mid_vsync_csync_low", int'(cs[100]), 0);
        @(negedge clk_dot4x);
        rst_n = 1'b0;
        @(negedge clk_dot4x);
        check("midrst_phase", int'(phase), 0);
        check("midrst_csync", int'(csync), 1);
        check("midrst_vsync_n", int'(vsync_n), 1);
        rst_n = 1'b1;
        run_line(18, 519, 1, -1);
        check("postrst_phase", int'(phase), 0);
        check("postrst_lows", lows, 38);
        check_pts(4, "postrst");

        // sync disabled from VSYNC through return to NORMAL
        for (int y = 12; y <= 15; y++) run_line(y, 519, 1, -1);
        sync_en = 1'b0;
        acc_lows = 0; acc_vlow = 0;
        for (int y = 16; y <= 22; y++) begin
            run_line(y, 519, 1, -1);
            acc_lows += lows; acc_vlow += vlow;
            if (y == 16) check("dis_y16_phase", int'(phase), 2);
        end
        check("dis_csync_lows", acc_lows, 0);
        check("dis_vsync_lows", acc_vlow, 0);
        check("dis_y22_phase", int'(phase), 0);

        // second field: re-enable partway through VSYNC line 2
        for (int y = 13; y <= 16; y++) run_line(y, 519, 1, -1);
        run_line(17, 519, 1, 100);
        check("reen_phase", int'(phase), 2);
        check("reen_vsync_n", int'(vsync_n), 0);
        check("reen_lows", lows, 358);
        check_pts(5, "reen");
        for (int y = 18; y <= 22; y++) run_line(y, 519, 1, -1);
        check("reen_y22_phase", int'(phase), 0);

        // PAL equalization and normal widths
        chip = C_PAL3;
        run_line(299, 519, 1, -1);
        check("pal_y299_phase", int'(phase), 0);
        check("pal_normal_lows", lows, 37);
        check_pts(3, "pal_normal");
        fs_cnt = 0;
        run_line(300, 519, 1, -1);
        check("pal_y300_phase", int'(phase), 1);
        check("pal_preeq_lows", lows, 40);
        check("pal_field_sync_pulses", fs_cnt, 1);
        check_pts(2, "pal_preeq");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
